// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer for a single-port
// data memory; latches a request in IDLE, strobes memory in ACC, returns in RESP.
module dmem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_regWrite,
  output logic              mem_regRead,
  input  logic [DATA_W-1:0] mem_readData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(DEPTH_WORDS);

  state_t state, state_nxt;

  logic              sel;
  logic              last;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              any_req;
  logic              win;
  logic [ADDR_W-1:0] word;
  logic              legal;

  assign any_req = req0 | req1;
  // On a tie the port that did not win last time gets the grant.
  assign win     = (req0 & req1) ? ~last : req1;

  assign word  = addr_q >> 2;
  assign legal = (addr_q[1:0] == 2'b00) && (word < DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel     <= 1'b0;
      last    <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && any_req) begin
      sel     <= win;
      last    <= win;
      we_q    <= win ? we1 : we0;
      addr_q  <= win ? addr1 : addr0;
      wdata_q <= win ? wdata1 : wdata0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACC;
      ACC:     state_nxt = (legal && !we_q) ? RESP : IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is high so an aborted
  // access never surfaces a late gnt or rvalid.
  always_comb begin
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    rvalid0       = 1'b0;
    rvalid1       = 1'b0;
    rdata         = '0;
    err           = 1'b0;
    busy          = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    mem_regWrite  = 1'b0;
    mem_regRead   = 1'b0;
    if (!reset) begin
      busy = (state != IDLE);
      case (state)
        ACC: begin
          gnt0 = ~sel;
          gnt1 = sel;
          if (legal) begin
            mem_address   = 32'(word);
            mem_writeData = wdata_q;
            mem_regWrite  = we_q;
            mem_regRead   = ~we_q;
          end else begin
            err = 1'b1;
          end
        end
        RESP: begin
          rvalid0 = ~sel;
          rvalid1 = sel;
          rdata   = mem_readData;
        end
        default: ;
      endcase
    end
  end

endmodule
